// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_pkg
// Description : Shared definitions for the multi-port register bank:
//               default widths, the read-port state encoding and the CPSR
//               flag bit positions used by issue-side logic.
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_pkg;

    // Default geometry of the bank
    localparam int c_def_data_w = 32;
    localparam int c_def_addr_w = 4;

    // Read-port FSM: IDLE accepts requests, WAIT holds a read stalled on a
    // register that is still awaiting writeback.
    typedef enum logic [0:0] {
        RP_IDLE = 1'b0,
        RP_WAIT = 1'b1
    } rp_state_t;

    // CPSR condition flag positions
    localparam int c_cpsr_n = 31;
    localparam int c_cpsr_z = 30;
    localparam int c_cpsr_c = 29;
    localparam int c_cpsr_v = 28;

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/regbank_rdport.sv
`default_nettype none
// ============================================================================
// Module      : regbank_rdport
// Description : One read port of the register bank. An unlocked read acks
//               one cycle after the request. A read of a pending register
//               parks in WAIT and is released by the writeback to that
//               index, which also supplies the returned data.
// Ports       : clk, rstN        - clock, asynchronous active-low reset
//               i_req, i_addr    - read request pulse and index
//               i_locked         - target is pending in the post-write view
//               i_fwd_data       - target contents in the post-write view
//               i_wr_req/addr/data - writeback bus, used to wake from WAIT
//               o_ack            - one-cycle data-valid pulse
//               o_data           - read data, held until the next ack
//               o_busy           - port holds a stalled read
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_rdport
    import regbank_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int ADDR_W = c_def_addr_w
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_locked,
    input  logic [DATA_W-1:0] i_fwd_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);

    rp_state_t         r_state;
    rp_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= RP_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            RP_IDLE: begin
                if (i_req) begin
                    if (i_locked) begin
                        w_state_nxt = RP_WAIT;
                        w_addr_nxt  = i_addr;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_ack_nxt  = 1'b1;
                        w_data_nxt = i_fwd_data;
                    end
                end
            end
            RP_WAIT: begin
                // Busy stays up through the ack cycle so the consumer sees
                // busy and ack overlap for one cycle on release.
                w_busy_nxt = 1'b1;
                if (i_wr_req && (i_wr_addr == r_addr)) begin
                    w_state_nxt = RP_IDLE;
                    w_ack_nxt   = 1'b1;
                    w_data_nxt  = i_wr_data;
                end
            end
            default: begin
                w_state_nxt = RP_IDLE;
            end
        endcase
    end

    assign o_ack  = r_ack;
    assign o_data = r_data;
    assign o_busy = r_busy;

endmodule : regbank_rdport
`default_nettype wire

// File: rtl/regbank_mp.sv
`default_nettype none
// ============================================================================
// Module      : regbank_mp
// Description : Multi-port register bank with NRD clocked read ports, one
//               writeback port, a PC update port and a masked CPSR. A busy
//               scoreboard marks registers awaiting writeback; reads of such
//               registers stall in their port until the write arrives.
// Ports       : clk, rstN                  - clock, async active-low reset
//               rdReqIn/rdAddrIn           - per-port read request / index
//               rdAckOut/rdDataOut/rdBusyOut - per-port ack, data, stall
//               wrReqIn/wrAddrIn/wrDataIn  - writeback
//               lockReqIn/lockAddrIn       - mark destination pending
//               pcWeIn/pcIn, pcOut         - PC update and current PC
//               cpsrWeIn/cpsrMaskIn/cpsrIn, cpsrOut - masked CPSR update
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int ADDR_W = c_def_addr_w,
    parameter int NRD    = 2,
    parameter int PC_IDX = (1 << ADDR_W) - 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [NRD-1:0]        rdReqIn,
    input  logic [NRD*ADDR_W-1:0] rdAddrIn,
    output logic [NRD-1:0]        rdAckOut,
    output logic [NRD*DATA_W-1:0] rdDataOut,
    output logic [NRD-1:0]        rdBusyOut,
    input  logic                  wrReqIn,
    input  logic [ADDR_W-1:0]     wrAddrIn,
    input  logic [DATA_W-1:0]     wrDataIn,
    input  logic                  lockReqIn,
    input  logic [ADDR_W-1:0]     lockAddrIn,
    input  logic                  pcWeIn,
    input  logic [DATA_W-1:0]     pcIn,
    output logic [DATA_W-1:0]     pcOut,
    input  logic                  cpsrWeIn,
    input  logic [DATA_W-1:0]     cpsrMaskIn,
    input  logic [DATA_W-1:0]     cpsrIn,
    output logic [DATA_W-1:0]     cpsrOut
);

    localparam int                c_nregs   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_pc_addr = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]  r_regs [c_nregs];
    logic [c_nregs-1:0] r_lock;
    logic [c_nregs-1:0] w_lock_nxt;
    logic [DATA_W-1:0]  r_cpsr;
    logic               w_pc_wr;

    // ------------------------------------------------------------------
    // Register array. A writeback to the PC index beats a fetch update
    // in the same cycle (branch target wins over sequential PC).
    // ------------------------------------------------------------------
    assign w_pc_wr = pcWeIn && !(wrReqIn && (wrAddrIn == c_pc_addr));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wrReqIn) begin
                r_regs[wrAddrIn] <= wrDataIn;
            end
            if (w_pc_wr) begin
                r_regs[PC_IDX] <= pcIn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard. The set is applied after the clear so a new
    // producer issued in the writeback cycle of the old one keeps the
    // register pending. Fetch PC updates never touch the lock bits.
    // ------------------------------------------------------------------
    always_comb begin
        w_lock_nxt = r_lock;
        if (wrReqIn) begin
            w_lock_nxt[wrAddrIn] = 1'b0;
        end
        if (lockReqIn) begin
            w_lock_nxt[lockAddrIn] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_lock <= '0;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end

    // ------------------------------------------------------------------
    // CPSR: per-bit masked update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cpsr <= '0;
        end else if (cpsrWeIn) begin
            r_cpsr <= (r_cpsr & ~cpsrMaskIn) | (cpsrIn & cpsrMaskIn);
        end
    end

    assign pcOut   = r_regs[PC_IDX];
    assign cpsrOut = r_cpsr;

    // ------------------------------------------------------------------
    // Read ports. Each sees its target in the post-write view: a
    // same-cycle writeback unlocks the target and forwards its data.
    // ------------------------------------------------------------------
    genvar gp;
    generate
        for (gp = 0; gp < NRD; gp++) begin : g_rdport
            logic [ADDR_W-1:0] w_addr;
            logic              w_wr_hit;
            logic              w_locked;
            logic [DATA_W-1:0] w_fwd_data;

            assign w_addr     = rdAddrIn[gp*ADDR_W +: ADDR_W];
            assign w_wr_hit   = wrReqIn && (wrAddrIn == w_addr);
            assign w_locked   = r_lock[w_addr] && !w_wr_hit;
            assign w_fwd_data = w_wr_hit ? wrDataIn : r_regs[w_addr];

            regbank_rdport #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_rdport (
                .clk        (clk),
                .rstN       (rstN),
                .i_req      (rdReqIn[gp]),
                .i_addr     (w_addr),
                .i_locked   (w_locked),
                .i_fwd_data (w_fwd_data),
                .i_wr_req   (wrReqIn),
                .i_wr_addr  (wrAddrIn),
                .i_wr_data  (wrDataIn),
                .o_ack      (rdAckOut[gp]),
                .o_data     (rdDataOut[gp*DATA_W +: DATA_W]),
                .o_busy     (rdBusyOut[gp])
            );
        end
    endgenerate

endmodule : regbank_mp
`default_nettype wire

// File: tb/tb_regbank_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_mp
// Description : Self-checking bench for regbank_mp: directed scenarios then
//               constrained-random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NRD    = 2;
    localparam int NREGS  = 16;
    localparam int PC_IDX = 15;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic [NRD-1:0]        rdReqIn;
    logic [NRD*ADDR_W-1:0] rdAddrIn;
    logic [NRD-1:0]        rdAckOut;
    logic [NRD*DATA_W-1:0] rdDataOut;
    logic [NRD-1:0]        rdBusyOut;
    logic                  wrReqIn;
    logic [ADDR_W-1:0]     wrAddrIn;
    logic [DATA_W-1:0]     wrDataIn;
    logic                  lockReqIn;
    logic [ADDR_W-1:0]     lockAddrIn;
    logic                  pcWeIn;
    logic [DATA_W-1:0]     pcIn;
    logic [DATA_W-1:0]     pcOut;
    logic                  cpsrWeIn;
    logic [DATA_W-1:0]     cpsrMaskIn;
    logic [DATA_W-1:0]     cpsrIn;
    logic [DATA_W-1:0]     cpsrOut;

    always #5 clk = ~clk;

    regbank_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .PC_IDX (PC_IDX)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .rdReqIn    (rdReqIn),
        .rdAddrIn   (rdAddrIn),
        .rdAckOut   (rdAckOut),
        .rdDataOut  (rdDataOut),
        .rdBusyOut  (rdBusyOut),
        .wrReqIn    (wrReqIn),
        .wrAddrIn   (wrAddrIn),
        .wrDataIn   (wrDataIn),
        .lockReqIn  (lockReqIn),
        .lockAddrIn (lockAddrIn),
        .pcWeIn     (pcWeIn),
        .pcIn       (pcIn),
        .pcOut      (pcOut),
        .cpsrWeIn   (cpsrWeIn),
        .cpsrMaskIn (cpsrMaskIn),
        .cpsrIn     (cpsrIn),
        .cpsrOut    (cpsrOut)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [NREGS];
    logic        m_lock [NREGS];
    logic [31:0] m_cpsr;
    int          m_pend [NRD];   // index a port is stalled on, -1 if none
    logic        m_ack  [NRD];
    logic [31:0] m_data [NRD];
    logic        m_busy [NRD];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_lock[i] = 1'b0;
        end
        m_cpsr = '0;
        for (int p = 0; p < NRD; p++) begin
            m_pend[p] = -1;
            m_ack[p]  = 1'b0;
            m_data[p] = '0;
            m_busy[p] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        for (int p = 0; p < NRD; p++) begin
            int a;
            a = int'(rdAddrIn[p*ADDR_W +: ADDR_W]);
            m_ack[p]  = 1'b0;
            m_busy[p] = 1'b0;
            if (m_pend[p] >= 0) begin
                m_busy[p] = 1'b1;
                if (wrReqIn && int'(wrAddrIn) == m_pend[p]) begin
                    m_ack[p]  = 1'b1;
                    m_data[p] = wrDataIn;
                    m_pend[p] = -1;
                end
            end else if (rdReqIn[p]) begin
                if (wrReqIn && int'(wrAddrIn) == a) begin
                    m_ack[p]  = 1'b1;
                    m_data[p] = wrDataIn;
                end else if (m_lock[a]) begin
                    m_pend[p] = a;
                    m_busy[p] = 1'b1;
                end else begin
                    m_ack[p]  = 1'b1;
                    m_data[p] = m_regs[a];
                end
            end
        end
        if (pcWeIn)    m_regs[PC_IDX]   = pcIn;
        if (wrReqIn)   m_regs[wrAddrIn] = wrDataIn;
        if (wrReqIn)   m_lock[wrAddrIn] = 1'b0;
        if (lockReqIn) m_lock[lockAddrIn] = 1'b1;
        if (cpsrWeIn)  m_cpsr = (m_cpsr & ~cpsrMaskIn) | (cpsrIn & cpsrMaskIn);
    endtask

    task automatic compare_all();
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("ack%0d", p),  32'(rdAckOut[p]), 32'(m_ack[p]));
            check($sformatf("data%0d", p), rdDataOut[p*DATA_W +: DATA_W], m_data[p]);
            check($sformatf("busy%0d", p), 32'(rdBusyOut[p]), 32'(m_busy[p]));
        end
        check("pcOut", pcOut, m_regs[PC_IDX]);
        check("cpsrOut", cpsrOut, m_cpsr);
    endtask

    task automatic clear_inputs();
        rdReqIn    = '0;
        rdAddrIn   = '0;
        wrReqIn    = 1'b0;
        wrAddrIn   = '0;
        wrDataIn   = '0;
        lockReqIn  = 1'b0;
        lockAddrIn = '0;
        pcWeIn     = 1'b0;
        pcIn       = '0;
        cpsrWeIn   = 1'b0;
        cpsrMaskIn = '0;
        cpsrIn     = '0;
    endtask

    // One clock: model predicts, DUT clocks, outputs compared 1ns after
    // the edge, then pulse inputs are dropped.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        clear_inputs();
    endtask

    task automatic rd(input int p, input int a);
        rdReqIn[p] = 1'b1;
        rdAddrIn[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wrReqIn  = 1'b1;
        wrAddrIn = ADDR_W'(a);
        wrDataIn = d;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rstN = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        rstN = 1'b1;

        // Plain read, then read-after-write
        rd(0, 3);
        cycle();
        check("r3_init_ack", 32'(rdAckOut[0]), 32'd1);
        check("r3_init", rdDataOut[31:0], 32'h0);
        cycle();
        wr(3, 32'h55);
        cycle();
        rd(0, 3);
        cycle();
        check("r3_55", rdDataOut[31:0], 32'h55);

        // Stall on a locked register, release by writeback
        lockReqIn  = 1'b1;
        lockAddrIn = 4'd5;
        cycle();
        rd(1, 5);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_busy", 32'(rdBusyOut[1]), 32'd1);
        end
        wr(5, 32'hDEAD);
        cycle();
        check("stall_ack", 32'(rdAckOut[1]), 32'd1);
        check("stall_data", rdDataOut[63:32], 32'hDEAD);
        cycle();
        check("stall_busy_drop", 32'(rdBusyOut[1]), 32'd0);

        // Same-cycle write forwarded to both ports
        wr(7, 32'h11);
        rd(0, 7);
        rd(1, 7);
        cycle();
        check("fwd_p0", rdDataOut[31:0], 32'h11);
        check("fwd_p1", rdDataOut[63:32], 32'h11);

        // PC arbitration
        wr(15, 32'h100);
        pcWeIn = 1'b1;
        pcIn   = 32'h204;
        cycle();
        check("pc_branch", pcOut, 32'h100);
        pcWeIn = 1'b1;
        pcIn   = 32'h208;
        cycle();
        check("pc_seq", pcOut, 32'h208);

        // Masked CPSR
        cpsrWeIn   = 1'b1;
        cpsrIn     = 32'hFFFF_FFFF;
        cpsrMaskIn = 32'hF000_0000;
        cycle();
        check("cpsr_set", cpsrOut, 32'hF000_0000);
        cpsrWeIn   = 1'b1;
        cpsrIn     = 32'h0;
        cpsrMaskIn = 32'h4000_0000;
        cycle();
        check("cpsr_clrz", cpsrOut, 32'hB000_0000);

        // Reset during a stall
        lockReqIn  = 1'b1;
        lockAddrIn = 4'd2;
        cycle();
        rd(0, 2);
        cycle();
        check("pre_rst_busy", 32'(rdBusyOut[0]), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 32'(rdBusyOut[0]), 32'd0);
        check("rst_ack", 32'(rdAckOut[0]), 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        rd(0, 2);
        cycle();
        check("post_rst_ack", 32'(rdAckOut[0]), 32'd1);
        check("post_rst_data", rdDataOut[31:0], 32'h0);

        // Constrained-random traffic
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NRD; p++) begin
                if (m_pend[p] < 0 && $urandom_range(0, 1) == 1) begin
                    rd(p, int'($urandom_range(0, 7)));
                end
            end
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 4) == 0) wr(int'($urandom_range(8, 15)), $urandom());
                else                           wr(int'($urandom_range(0, 7)), $urandom());
            end
            if ($urandom_range(0, 9) < 3) begin
                lockReqIn  = 1'b1;
                lockAddrIn = ADDR_W'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 4) == 0) begin
                pcWeIn = 1'b1;
                pcIn   = $urandom();
            end
            if ($urandom_range(0, 4) == 0) begin
                cpsrWeIn   = 1'b1;
                cpsrIn     = $urandom();
                cpsrMaskIn = $urandom();
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regbank_mp
`default_nettype wire
